dlx_mem_responder: RTL and testbench

Memory-side responder for the uDLX core's instruction and data ports, answering the core's instr_rd_en/instr_addr fetches and data_rd_en/data_wr_en accesses. Holds on-chip instruction and data RAM banks with a fixed 1-cycle registered read latency, which matches the core's write-back timing.
Includes a boot-load state machine that holds the core in reset while a host preloads both banks. Out-of-range and misaligned accesses are flagged as faults.

---
 rtl/dlx_mem_pkg.sv | 29 ++
 rtl/dlx_mem_bank.sv | 46 ++++
 rtl/dlx_mem_responder.sv | 209 ++++++++++++++++++++
 tb/tb_dlx_mem_responder.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dlx_mem_pkg.sv
// Shared types and constants for the uDLX memory responder.
// The optional fault counter is enabled with the DLX_MEM_FAULT_CNT_EN macro.
package dlx_mem_pkg;

    typedef enum logic [0:0] {
        BOOT = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam logic LOAD_SEL_IMEM = 1'b0;
    localparam logic LOAD_SEL_DMEM = 1'b1;

    localparam int FAULT_CNT_WIDTH = 16;

    // Saturating add of this cycle's fault events onto the running count.
    function automatic logic [FAULT_CNT_WIDTH-1:0] sat_add(
        input logic [FAULT_CNT_WIDTH-1:0] cnt,
        input logic [1:0]                 inc
    );
        logic [FAULT_CNT_WIDTH:0] sum;
        sum = {1'b0, cnt} + {{(FAULT_CNT_WIDTH-1){1'b0}}, inc};
        if (sum[FAULT_CNT_WIDTH]) begin
            sat_add = {FAULT_CNT_WIDTH{1'b1}};
        end else begin
            sat_add = sum[FAULT_CNT_WIDTH-1:0];
        end
    endfunction

endpackage

// File: rtl/dlx_mem_bank.sv
// Single-port synchronous RAM bank with a 1-cycle registered read port that
// holds its value when no read is requested; clr forces the read register to 0.
module dlx_mem_bank
    import dlx_mem_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic                  re,
    input  logic                  clr,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_r;

    // Storage array write; contents survive reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[addr] <= wdata;
        end
    end

    // Registered read port.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_r <= '0;
        end else if (clr) begin
            rdata_r <= '0;
        end else if (re) begin
            rdata_r <= mem_r[addr];
        end else begin
            rdata_r <= rdata_r;
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/dlx_mem_responder.sv
// Instruction/data memory responder for the uDLX core with host boot-load FSM.
// Define DLX_MEM_FAULT_CNT_EN to build the saturating fault_count counter.
module dlx_mem_responder
    import dlx_mem_pkg::*;
#(
    parameter int                         DATA_WIDTH      = 32,
    parameter int                         INST_ADDR_WIDTH = 20,
    parameter int                         DATA_ADDR_WIDTH = 32,
    parameter int                         IMEM_DEPTH_LOG2 = 10,
    parameter int                         DMEM_DEPTH_LOG2 = 10,
    parameter logic [INST_ADDR_WIDTH-1:0] IMEM_BASE       = 20'h40000,
    parameter logic [DATA_ADDR_WIDTH-1:0] DMEM_BASE       = 32'h0,
    localparam int LOAD_ADDR_WIDTH =
        (IMEM_DEPTH_LOG2 > DMEM_DEPTH_LOG2) ? IMEM_DEPTH_LOG2 : DMEM_DEPTH_LOG2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       instr_rd_en,
    input  logic [INST_ADDR_WIDTH-1:0] instr_addr,
    output logic [DATA_WIDTH-1:0]      instruction,
    input  logic                       data_rd_en,
    input  logic                       data_wr_en,
    input  logic [DATA_ADDR_WIDTH-1:0] data_addr,
    input  logic [DATA_WIDTH-1:0]      data_write,
    output logic [DATA_WIDTH-1:0]      data_read,
    input  logic                       load_valid,
    input  logic                       load_sel,
    input  logic [LOAD_ADDR_WIDTH-1:0] load_addr,
    input  logic [DATA_WIDTH-1:0]      load_data,
    input  logic                       load_done,
    output logic                       core_rst_n,
    output logic                       fault,
    output logic [FAULT_CNT_WIDTH-1:0] fault_count
);

    state_e state_r, state_next_s;

    logic [INST_ADDR_WIDTH-1:0] i_off_s;
    logic [DATA_ADDR_WIDTH-1:0] d_off_s;
    logic                       i_ok_s, d_ok_s;

    logic                       imem_we_s, imem_re_s, imem_clr_s;
    logic [IMEM_DEPTH_LOG2-1:0] imem_addr_s;
    logic                       dmem_we_s, dmem_re_s, dmem_clr_s;
    logic [DMEM_DEPTH_LOG2-1:0] dmem_addr_s;
    logic [DATA_WIDTH-1:0]      dmem_wdata_s;

    logic                       i_ev_s, d_ev_s;
    logic [1:0]                 ev_cnt_s;

    logic                       core_rst_n_r;
    logic                       fault_r;

    // Bases are word aligned, so offset bits [1:0] equal the address bits [1:0].
    assign i_off_s = instr_addr - IMEM_BASE;
    assign d_off_s = data_addr - DMEM_BASE;
    assign i_ok_s  = (i_off_s[INST_ADDR_WIDTH-1:IMEM_DEPTH_LOG2+2] == '0) && (i_off_s[1:0] == 2'b00);
    assign d_ok_s  = (d_off_s[DATA_ADDR_WIDTH-1:DMEM_DEPTH_LOG2+2] == '0) && (d_off_s[1:0] == 2'b00);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= BOOT;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            BOOT: begin
                if (load_done) begin
                    state_next_s = RUN;
                end else begin
                    state_next_s = BOOT;
                end
            end
            RUN:     state_next_s = RUN;
            default: state_next_s = BOOT;
        endcase
    end

    // Bank port muxing between the host loader and the core, plus fault events.
    always_comb begin
        imem_we_s    = 1'b0;
        imem_re_s    = 1'b0;
        imem_clr_s   = 1'b0;
        imem_addr_s  = i_off_s[IMEM_DEPTH_LOG2+1:2];
        dmem_we_s    = 1'b0;
        dmem_re_s    = 1'b0;
        dmem_clr_s   = 1'b0;
        dmem_addr_s  = d_off_s[DMEM_DEPTH_LOG2+1:2];
        dmem_wdata_s = data_write;
        i_ev_s       = 1'b0;
        d_ev_s       = 1'b0;
        if (rst) begin
            imem_we_s = 1'b0;
            dmem_we_s = 1'b0;
        end else begin
            case (state_r)
                BOOT: begin
                    if (load_valid && (load_sel == LOAD_SEL_IMEM)) begin
                        imem_we_s   = 1'b1;
                        imem_addr_s = load_addr[IMEM_DEPTH_LOG2-1:0];
                    end else if (load_valid && (load_sel == LOAD_SEL_DMEM)) begin
                        dmem_we_s    = 1'b1;
                        dmem_addr_s  = load_addr[DMEM_DEPTH_LOG2-1:0];
                        dmem_wdata_s = load_data;
                    end else begin
                        imem_we_s = 1'b0;
                        dmem_we_s = 1'b0;
                    end
                end
                RUN: begin
                    if (instr_rd_en) begin
                        imem_re_s  = i_ok_s;
                        imem_clr_s = ~i_ok_s;
                        i_ev_s     = ~i_ok_s;
                    end else begin
                        imem_re_s = 1'b0;
                    end
                    // Colliding enables still store, but the load is refused.
                    if (data_wr_en && data_rd_en) begin
                        dmem_we_s  = d_ok_s;
                        dmem_clr_s = 1'b1;
                        d_ev_s     = 1'b1;
                    end else if (data_wr_en) begin
                        dmem_we_s = d_ok_s;
                        d_ev_s    = ~d_ok_s;
                    end else if (data_rd_en) begin
                        dmem_re_s  = d_ok_s;
                        dmem_clr_s = ~d_ok_s;
                        d_ev_s     = ~d_ok_s;
                    end else begin
                        dmem_re_s = 1'b0;
                    end
                end
                default: begin
                    imem_we_s = 1'b0;
                    dmem_we_s = 1'b0;
                end
            endcase
        end
    end

    assign ev_cnt_s = {1'b0, i_ev_s} + {1'b0, d_ev_s};

    dlx_mem_bank #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH_LOG2 (IMEM_DEPTH_LOG2)
    ) u_imem (
        .clk   (clk),
        .rst   (rst),
        .we    (imem_we_s),
        .re    (imem_re_s),
        .clr   (imem_clr_s),
        .addr  (imem_addr_s),
        .wdata (load_data),
        .rdata (instruction)
    );

    dlx_mem_bank #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH_LOG2 (DMEM_DEPTH_LOG2)
    ) u_dmem (
        .clk   (clk),
        .rst   (rst),
        .we    (dmem_we_s),
        .re    (dmem_re_s),
        .clr   (dmem_clr_s),
        .addr  (dmem_addr_s),
        .wdata (dmem_wdata_s),
        .rdata (data_read)
    );

    // Core reset release and sticky fault flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            core_rst_n_r <= 1'b0;
            fault_r      <= 1'b0;
        end else begin
            core_rst_n_r <= (state_next_s == RUN);
            fault_r      <= fault_r | (ev_cnt_s != 2'd0);
        end
    end

    assign core_rst_n = core_rst_n_r;
    assign fault      = fault_r;

`ifdef DLX_MEM_FAULT_CNT_EN
    logic [FAULT_CNT_WIDTH-1:0] fault_count_r;

    // Saturating fault event counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            fault_count_r <= '0;
        end else begin
            fault_count_r <= sat_add(fault_count_r, ev_cnt_s);
        end
    end

    assign fault_count = fault_count_r;
`else
    assign fault_count = {FAULT_CNT_WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_dlx_mem_responder.sv
// Scoreboard bench for dlx_mem_responder: randomized traffic against a behavioural memory model.
module tb_dlx_mem_responder;

    logic        clk;
    logic        rst;
    logic        instr_rd_en;
    logic [19:0] instr_addr;
    logic [31:0] instruction;
    logic        data_rd_en;
    logic        data_wr_en;
    logic [31:0] data_addr;
    logic [31:0] data_write;
    logic [31:0] data_read;
    logic        load_valid;
    logic        load_sel;
    logic [9:0]  load_addr;
    logic [31:0] load_data;
    logic        load_done;
    logic        core_rst_n;
    logic        fault;
    logic [15:0] fault_count;

    dlx_mem_responder dut (
        .clk         (clk),
        .rst         (rst),
        .instr_rd_en (instr_rd_en),
        .instr_addr  (instr_addr),
        .instruction (instruction),
        .data_rd_en  (data_rd_en),
        .data_wr_en  (data_wr_en),
        .data_addr   (data_addr),
        .data_write  (data_write),
        .data_read   (data_read),
        .load_valid  (load_valid),
        .load_sel    (load_sel),
        .load_addr   (load_addr),
        .load_data   (load_data),
        .load_done   (load_done),
        .core_rst_n  (core_rst_n),
        .fault       (fault),
        .fault_count (fault_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] dread;
        logic        flt;
        logic        crn;
        logic [15:0] cnt;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    // Reference model state
    bit          m_run   = 1'b0;
    logic [31:0] m_imem [1024];
    logic [31:0] m_dmem [1024];
    logic [31:0] m_instr = 32'h0;
    logic [31:0] m_dread = 32'h0;
    bit          m_fault = 1'b0;
    int          m_cnt   = 0;

    task automatic step(input logic r,
                        input logic ird, input logic [19:0] ia,
                        input logic drd, input logic dwr,
                        input logic [31:0] da, input logic [31:0] dw,
                        input logic lv, input logic ls, input logic [9:0] la,
                        input logic [31:0] ld, input logic ldone);
        int          ev;
        logic [19:0] ioff;
        bit          dok;
        exp_t        e;
        @(negedge clk);
        rst = r; instr_rd_en = ird; instr_addr = ia;
        data_rd_en = drd; data_wr_en = dwr; data_addr = da; data_write = dw;
        load_valid = lv; load_sel = ls; load_addr = la; load_data = ld; load_done = ldone;
        if (r) begin
            m_run = 1'b0; m_instr = 32'h0; m_dread = 32'h0; m_fault = 1'b0; m_cnt = 0;
        end else if (!m_run) begin
            if (lv) begin
                if (ls) m_dmem[la] = ld;
                else    m_imem[la] = ld;
            end
            if (ldone) m_run = 1'b1;
        end else begin
            ev = 0;
            if (ird) begin
                ioff = ia - 20'h40000;
                if (ioff < 20'd4096 && ia[1:0] == 2'b00) m_instr = m_imem[ioff[11:2]];
                else begin m_instr = 32'h0; ev++; end
            end
            dok = (da < 32'd4096) && (da[1:0] == 2'b00);
            if (dwr && drd) begin
                if (dok) m_dmem[da[11:2]] = dw;
                m_dread = 32'h0; ev++;
            end else if (dwr) begin
                if (dok) m_dmem[da[11:2]] = dw;
                else ev++;
            end else if (drd) begin
                if (dok) m_dread = m_dmem[da[11:2]];
                else begin m_dread = 32'h0; ev++; end
            end
            if (ev > 0) m_fault = 1'b1;
            m_cnt = m_cnt + ev;
            if (m_cnt > 65535) m_cnt = 65535;
        end
        e.instr = m_instr;
        e.dread = m_dread;
        e.flt   = m_fault;
        e.crn   = m_run;
`ifdef DLX_MEM_FAULT_CNT_EN
        e.cnt   = 16'(m_cnt);
`else
        e.cnt   = 16'h0;
`endif
        sb_q.push_back(e);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 20'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 10'h0, 32'h0, 1'b0);
    endtask

    task automatic core(input logic ird, input logic [19:0] ia, input logic drd,
                        input logic dwr, input logic [31:0] da, input logic [31:0] dw);
        step(1'b0, ird, ia, drd, dwr, da, dw, 1'b0, 1'b0, 10'h0, 32'h0, 1'b0);
    endtask

    function automatic logic [19:0] rand_iaddr();
        case ($urandom_range(0, 9))
            0:       return 20'h40000 + 20'($urandom_range(0, 4095)) | 20'h1;
            1:       return 20'h40000 - 20'(4 * $urandom_range(1, 64));
            2:       return 20'h41000 + 20'(4 * $urandom_range(0, 64));
            default: return 20'h40000 + 20'(4 * $urandom_range(0, 1023));
        endcase
    endfunction

    function automatic logic [31:0] rand_daddr();
        case ($urandom_range(0, 9))
            0:       return 32'($urandom_range(0, 4095)) | 32'h2;
            1:       return 32'hFFFF_FFFC - 32'(4 * $urandom_range(0, 16));
            2:       return 32'h1000 + 32'(4 * $urandom_range(0, 64));
            3, 4, 5: return 32'(4 * $urandom_range(0, 7));
            default: return 32'(4 * $urandom_range(0, 1023));
        endcase
    endfunction

    // Monitor: compare every registered output against the scoreboard head.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                n_vec++;
                if (instruction !== e.instr) begin
                    n_miss++;
                    $display("FAIL instruction: got %h, expected %h at %0t", instruction, e.instr, $time);
                end
                if (data_read !== e.dread) begin
                    n_miss++;
                    $display("FAIL data_read: got %h, expected %h at %0t", data_read, e.dread, $time);
                end
                if (fault !== e.flt) begin
                    n_miss++;
                    $display("FAIL fault: got %b, expected %b at %0t", fault, e.flt, $time);
                end
                if (core_rst_n !== e.crn) begin
                    n_miss++;
                    $display("FAIL core_rst_n: got %b, expected %b at %0t", core_rst_n, e.crn, $time);
                end
                if (fault_count !== e.cnt) begin
                    n_miss++;
                    $display("FAIL fault_count: got %h, expected %h at %0t", fault_count, e.cnt, $time);
                end
            end
        end
    end

    initial begin
        rst = 1'b1; instr_rd_en = 1'b0; instr_addr = 20'h0; data_rd_en = 1'b0;
        data_wr_en = 1'b0; data_addr = 32'h0; data_write = 32'h0; load_valid = 1'b0;
        load_sel = 1'b0; load_addr = 10'h0; load_data = 32'h0; load_done = 1'b0;

        repeat (2) step(1'b1, 1'b1, 20'h40000, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 10'h0, 32'h0, 1'b0);

        // Preload both banks while core ports are active and must be ignored.
        for (int i = 0; i < 1024; i++) begin
            logic [31:0] w;
            w = (i == 0) ? 32'h20010005 : (i == 1) ? 32'h8C220000 : 32'($urandom);
            step(1'b0, 1'b1, 20'h40000, 1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 10'(i), w, 1'b0);
        end
        for (int i = 0; i < 1024; i++) begin
            step(1'b0, 1'b1, 20'h40004, 1'b0, 1'b1, 32'h10, 32'h0, 1'b1, 1'b1, 10'(i),
                 32'($urandom), (i == 1023) ? 1'b1 : 1'b0);
        end

        // Directed RUN scenarios
        core(1'b1, 20'h40000, 1'b0, 1'b0, 32'h0, 32'h0);
        core(1'b0, 20'h0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
        core(1'b0, 20'h0, 1'b1, 1'b0, 32'h10, 32'h0);
        idle();
        core(1'b1, 20'h40004, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (3) core(1'b0, 20'h40FFF, 1'b0, 1'b0, 32'h0, 32'h0);
        core(1'b1, 20'h40FFC, 1'b1, 1'b0, 32'hFFC, 32'h0);
        core(1'b0, 20'h0, 1'b1, 1'b0, 32'h00001002, 32'h0);
        core(1'b1, 20'h3FFFC, 1'b1, 1'b1, 32'h20, 32'h12345678);
        core(1'b0, 20'h0, 1'b1, 1'b0, 32'h20, 32'h0);
        core(1'b1, 20'h41000, 1'b1, 1'b0, 32'h1000, 32'h0);
        core(1'b0, 20'h0, 1'b0, 1'b1, 32'h1000, 32'h55AA55AA);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            core(1'($urandom), rand_iaddr(), 1'($urandom), 1'($urandom), rand_daddr(), 32'($urandom));
        end

        // Reset mid-run, reload only IMEM, then confirm DMEM contents survived.
        step(1'b1, 1'b1, 20'h40000, 1'b1, 1'b1, 32'h10, 32'h0, 1'b0, 1'b0, 10'h0, 32'h0, 1'b0);
        step(1'b0, 1'b0, 20'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 10'h2, 32'hCAFEF00D, 1'b0);
        step(1'b0, 1'b1, 20'h40008, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 10'h0, 32'h0, 1'b1);
        core(1'b1, 20'h40008, 1'b1, 1'b0, 32'h10, 32'h0);
        core(1'b0, 20'h0, 1'b1, 1'b0, 32'h20, 32'h0);
        for (int i = 0; i < 300; i++) begin
            core(1'($urandom), rand_iaddr(), 1'($urandom), 1'($urandom), rand_daddr(), 32'($urandom));
        end
        idle();

        @(posedge clk);
        #2;
        if (sb_q.size() != 0) begin
            n_miss++;
            $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
